// File: rtl/text_entry_ctrl.sv
// Button/switch front end for the character display: debounces pushbuttons, writes
// characters into tile RAM, tracks the text cursor and its blink, and sweeps a full clear.
module text_entry_ctrl #(
  parameter int COLS            = 60,
  parameter int ROWS            = 17,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLINK_FRAMES    = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  btn,
  input  logic [6:0]  sw,
  input  logic        frame_tick,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [6:0]  wr_data,
  output logic [5:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        cursor_on,
  output logic        busy,
  output logic [9:0]  status_leds
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state, state_next;
  logic [2:0]      sync1, sync2, db_level, db_level_d, press;
  logic [DB_W-1:0] db_cnt [3];
  logic [6:0]      sw_q, last_char, last_char_next, wr_data_next;
  logic [5:0]      sweep_col;
  logic [4:0]      sweep_row;
  logic [10:0]     wr_addr_next, cur_next, sweep_next;
  logic [BL_W-1:0] blink_cnt, blink_next;
  logic            wr_en_next, cursor_on_next, cursor_moved;

  // Row-major step with wrap from the bottom-right cell back to the top-left.
  function automatic logic [10:0] advance(input logic [4:0] row, input logic [5:0] col);
    logic [4:0] r;
    logic [5:0] c;
    r = row;
    c = col + 6'd1;
    if (col == LAST_COL) begin
      c = '0;
      r = (row == LAST_ROW) ? 5'd0 : row + 5'd1;
    end
    return {r, c};
  endfunction

  // The debounce counter only runs while the synced level disagrees with the debounced one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      db_level   <= '0;
      db_level_d <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1      <= btn;
      sync2      <= sync1;
      db_level_d <= db_level;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_level[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign press = db_level & ~db_level_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cur_row   <= '0;
      cur_col   <= '0;
      sweep_row <= '0;
      sweep_col <= '0;
      last_char <= '0;
      sw_q      <= '0;
      blink_cnt <= '0;
      cursor_on <= 1'b1;
    end else begin
      state                  <= state_next;
      wr_en                  <= wr_en_next;
      wr_addr                <= wr_addr_next;
      wr_data                <= wr_data_next;
      {cur_row, cur_col}     <= cur_next;
      {sweep_row, sweep_col} <= sweep_next;
      last_char              <= last_char_next;
      sw_q                   <= sw;
      blink_cnt              <= blink_next;
      cursor_on              <= cursor_on_next;
    end
  end

  // The first clear write goes out on the entry edge, so the sweep register runs one cell ahead.
  always_comb begin
    state_next     = state;
    wr_en_next     = 1'b0;
    wr_addr_next   = wr_addr;
    wr_data_next   = wr_data;
    cur_next       = {cur_row, cur_col};
    sweep_next     = {sweep_row, sweep_col};
    last_char_next = last_char;
    cursor_moved   = 1'b0;
    case (state)
      IDLE: begin
        if (press[2]) begin
          state_next   = CLEAR;
          wr_en_next   = 1'b1;
          wr_addr_next = '0;
          wr_data_next = 7'h20;
          sweep_next   = advance(5'd0, 6'd0);
        end else if (press[0]) begin
          wr_en_next     = 1'b1;
          wr_addr_next   = {cur_row, cur_col};
          wr_data_next   = sw_q;
          last_char_next = sw_q;
          cur_next       = advance(cur_row, cur_col);
          cursor_moved   = 1'b1;
        end else if (press[1]) begin
          cur_next     = advance(cur_row, cur_col);
          cursor_moved = 1'b1;
        end
      end
      CLEAR: begin
        if (wr_addr == {LAST_ROW, LAST_COL}) begin
          state_next   = IDLE;
          cur_next     = '0;
          cursor_moved = 1'b1;
        end else begin
          wr_en_next   = 1'b1;
          wr_addr_next = {sweep_row, sweep_col};
          wr_data_next = 7'h20;
          sweep_next   = advance(sweep_row, sweep_col);
        end
      end
      default: state_next = IDLE;
    endcase

    blink_next     = blink_cnt;
    cursor_on_next = cursor_on;
    if (cursor_moved) begin
      blink_next     = '0;
      cursor_on_next = 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == BL_W'(BLINK_FRAMES - 1)) begin
        blink_next     = '0;
        cursor_on_next = ~cursor_on;
      end else begin
        blink_next = blink_cnt + BL_W'(1);
      end
    end
  end

  assign busy        = (state == CLEAR);
  assign status_leds = {busy, cursor_on, 1'b0, last_char};

endmodule

// File: tb/tb_text_entry_ctrl.sv
// Directed self-checking bench for text_entry_ctrl with a short debounce (4 cycles).
module tb_text_entry_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  btn = '0;
  logic [6:0]  sw = '0;
  logic        frame_tick = 1'b0;
  logic        wr_en, cursor_on, busy;
  logic [10:0] wr_addr;
  logic [6:0]  wr_data;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;
  logic [9:0]  status_leds;

  int checks = 0;
  int passes = 0;
  int cycle = 0;
  int wr_count = 0;
  int last_wr_cycle = 0;
  logic [10:0] last_wr_addr = '0;
  logic [6:0]  last_wr_data = '0;

  text_entry_ctrl #(
    .COLS(60), .ROWS(17), .DEBOUNCE_CYCLES(4), .BLINK_FRAMES(30)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .sw(sw), .frame_tick(frame_tick),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cur_col(cur_col), .cur_row(cur_row), .cursor_on(cursor_on),
    .busy(busy), .status_leds(status_leds)
  );

  always #5 clk = ~clk;

  // Write log sampled just after each rising edge.
  always @(posedge clk) begin
    cycle = cycle + 1;
    #1;
    if (wr_en === 1'b1) begin
      wr_count      = wr_count + 1;
      last_wr_cycle = cycle;
      last_wr_addr  = wr_addr;
      last_wr_data  = wr_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [2:0] mask, input logic [6:0] sw_val, input int hold, input int rel);
    sw  = sw_val;
    btn = mask;
    repeat (hold) @(negedge clk);
    btn = '0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  // Watches a clear started by the caller; optionally presses btn[0] mid-sweep.
  task automatic watchSweep(input bit inject, output int first_k, output int n_wr,
                            output int bad, output bit done, output bit busy_seen);
    logic [4:0] er;
    logic [5:0] ec;
    bit started;
    er = '0; ec = '0; started = 0;
    first_k = 0; n_wr = 0; bad = 0; done = 0; busy_seen = 0;
    for (int k = 1; k <= 1300 && !done; k++) begin
      @(negedge clk);
      if (k == 10) btn = '0;
      if (inject && k == 20) btn = 3'b001;
      if (inject && k == 40) btn = 3'b000;
      if (wr_en === 1'b1) begin
        if (!started) begin
          first_k   = k;
          busy_seen = busy;
        end
        started = 1;
        if (wr_addr !== {er, ec} || wr_data !== 7'h20) bad++;
        n_wr++;
        if (ec == 6'd59) begin
          ec = '0;
          er = (er == 5'd16) ? 5'd0 : er + 5'd1;
        end else begin
          ec = ec + 6'd1;
        end
      end else if (started) begin
        done = 1;
      end
    end
  endtask

  initial begin
    int c0, w0, first_k, n_wr, bad, n;
    bit done, busy_seen;

    @(negedge clk);
    checkOutput("reset_wr_en", 32'(wr_en), 32'd0);
    checkOutput("reset_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("reset_wr_data", 32'(wr_data), 32'd0);
    checkOutput("reset_cursor", 32'({cur_row, cur_col}), 32'd0);
    checkOutput("reset_leds", 32'(status_leds), 32'h100);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single write");
    c0 = cycle; w0 = wr_count;
    applyStimulus(3'b001, 7'h41, 10, 10);
    checkOutput("write_count", 32'(wr_count - w0), 32'd1);
    checkOutput("write_latency", 32'(last_wr_cycle - c0), 32'd7);
    checkOutput("write_addr", 32'(last_wr_addr), 32'd0);
    checkOutput("write_data", 32'(last_wr_data), 32'h41);
    checkOutput("write_cursor", 32'({cur_row, cur_col}), 32'({5'd0, 6'd1}));
    checkOutput("write_leds_char", 32'(status_leds[6:0]), 32'h41);

    $display("[TB] advance to bottom-right and wrap");
    w0 = wr_count;
    for (int i = 0; i < 1018; i++) applyStimulus(3'b010, 7'h00, 8, 8);
    checkOutput("adv_bottom_right", 32'({cur_row, cur_col}), 32'({5'd16, 6'd59}));
    repeat (5) tick();
    applyStimulus(3'b010, 7'h00, 8, 8);
    checkOutput("wrap_no_write", 32'(wr_count - w0), 32'd0);
    checkOutput("wrap_cursor", 32'({cur_row, cur_col}), 32'd0);
    checkOutput("wrap_cursor_on", 32'(cursor_on), 32'd1);
    repeat (29) tick();
    checkOutput("wrap_blink_29", 32'(cursor_on), 32'd1);
    tick();
    checkOutput("wrap_blink_30", 32'(cursor_on), 32'd0);

    $display("[TB] clear with ignored press");
    applyStimulus(3'b010, 7'h00, 8, 8);
    w0 = wr_count;
    btn = 3'b100;
    watchSweep(1'b1, first_k, n_wr, bad, done, busy_seen);
    checkOutput("clear_done", 32'(done), 32'd1);
    checkOutput("clear_first", 32'(first_k), 32'd7);
    checkOutput("clear_busy_first", 32'(busy_seen), 32'd1);
    checkOutput("clear_writes", 32'(n_wr), 32'd1020);
    checkOutput("clear_bad_cells", 32'(bad), 32'd0);
    checkOutput("clear_busy_end", 32'(busy), 32'd0);
    checkOutput("clear_cursor", 32'({cur_row, cur_col}), 32'd0);
    repeat (30) @(negedge clk);
    checkOutput("clear_ignored_press", 32'(wr_count - w0), 32'd1020);
    checkOutput("clear_cursor_after", 32'({cur_row, cur_col}), 32'd0);

    $display("[TB] bounce");
    w0 = wr_count;
    sw = 7'h42;
    for (int k = 0; k < 40; k++) begin
      btn = {2'b00, ((k / 2) % 2) == 0};
      @(negedge clk);
    end
    c0 = cycle;
    applyStimulus(3'b001, 7'h42, 12, 10);
    checkOutput("bounce_count", 32'(wr_count - w0), 32'd1);
    checkOutput("bounce_latency", 32'(last_wr_cycle - c0), 32'd7);
    checkOutput("bounce_data", 32'(last_wr_data), 32'h42);
    checkOutput("bounce_cursor", 32'({cur_row, cur_col}), 32'({5'd0, 6'd1}));

    $display("[TB] simultaneous write and clear");
    sw = 7'h43;
    btn = 3'b101;
    watchSweep(1'b0, first_k, n_wr, bad, done, busy_seen);
    checkOutput("simul_writes", 32'(n_wr), 32'd1020);
    checkOutput("simul_bad_cells", 32'(bad), 32'd0);
    checkOutput("simul_last_char", 32'(status_leds[6:0]), 32'h42);
    checkOutput("simul_cursor", 32'({cur_row, cur_col}), 32'd0);

    $display("[TB] reset mid-clear");
    repeat (10) @(negedge clk);
    w0 = wr_count;
    n = 0;
    btn = 3'b100;
    for (int k = 1; k <= 300 && n < 100; k++) begin
      @(negedge clk);
      if (k == 10) btn = '0;
      if (wr_en === 1'b1) n++;
    end
    checkOutput("midclear_reached", 32'(n), 32'd100);
    reset = 1'b0;
    #1;
    checkOutput("midclear_wr_en", 32'(wr_en), 32'd0);
    checkOutput("midclear_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("midclear_writes", 32'(wr_count - w0), 32'd100);
    checkOutput("midclear_idle", 32'(busy), 32'd0);
    repeat (29) tick();
    checkOutput("blink_29", 32'(cursor_on), 32'd1);
    tick();
    checkOutput("blink_30", 32'(cursor_on), 32'd0);
    checkOutput("blink_leds", 32'(status_leds), 32'h000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
